// File: rtl/truth_table_sweeper.sv
// Drives all 16 input vectors into a 4-input combinational block and captures its truth table.
// Define TT_SWEEP_CHECK_EN to compile in the golden-table compare (EXPECTED, mismatch, err_count).
module truth_table_sweeper #(
    parameter int HOLD_CYCLES = 10
`ifdef TT_SWEEP_CHECK_EN
    ,
    parameter logic [15:0] EXPECTED = 16'h0000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        f,
    output logic        x,
    output logic        y,
    output logic        w,
    output logic        z,
    output logic        busy,
    output logic        done,
    output logic [3:0]  index,
    output logic [15:0] truth_table
`ifdef TT_SWEEP_CHECK_EN
    ,
    output logic        mismatch,
    output logic [4:0]  err_count
`endif
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] hold_cnt;

    // busy mirrors state == DRIVE, so it doubles as the visible FSM state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            index       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= '0;
`ifdef TT_SWEEP_CHECK_EN
            mismatch    <= 1'b0;
            err_count   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= DRIVE;
                        busy        <= 1'b1;
                        index       <= '0;
                        hold_cnt    <= '0;
                        truth_table <= '0;
`ifdef TT_SWEEP_CHECK_EN
                        mismatch    <= 1'b0;
                        err_count   <= '0;
`endif
                    end
                end
                DRIVE: begin
                    if (hold_cnt == LAST) begin
                        // f has settled for HOLD_CYCLES-1 full cycles on this vector.
                        truth_table[index] <= f;
                        hold_cnt           <= '0;
`ifdef TT_SWEEP_CHECK_EN
                        if (f != EXPECTED[index]) begin
                            mismatch <= 1'b1;
                            if (err_count != 5'd16) err_count <= err_count + 5'd1;
                        end
`endif
                        if (index == 4'd15) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            index <= '0;
                        end else begin
                            index <= index + 4'd1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // index is zero whenever idle, so stimulus returns to 0000 outside a sweep.
    assign {x, y, w, z} = index;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized bench for truth_table_sweeper: cycle-level reference model plus a done-driven scoreboard.
module tb_truth_table_sweeper;

    localparam int HOLD  = 10;
    localparam int SWEEP = 16 * HOLD;
    localparam logic [15:0] GOLDEN = 16'h6996;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        f;
    logic        x, y, w, z, busy, done;
    logic [3:0]  index;
    logic [15:0] truth_table;
`ifdef TT_SWEEP_CHECK_EN
    logic        mismatch;
    logic [4:0]  err_count;
    int          exp_errs;
`endif

    logic [15:0] fn_table = 16'h0000;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_result;
    int          elapsed = -1;
    logic        exp_done = 1'b0;
    logic [15:0] exp_tt = 16'h0000;
    logic [3:0]  exp_index;

    truth_table_sweeper #(
        .HOLD_CYCLES(HOLD)
`ifdef TT_SWEEP_CHECK_EN
        ,
        .EXPECTED(GOLDEN)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .f(f),
        .x(x),
        .y(y),
        .w(w),
        .z(z),
        .busy(busy),
        .done(done),
        .index(index),
        .truth_table(truth_table)
`ifdef TT_SWEEP_CHECK_EN
        ,
        .mismatch(mismatch),
        .err_count(err_count)
`endif
    );

    // Clock and the combinational circuit under sweep.
    always #5 clk = ~clk;
    always_comb f = fn_table[{x, y, w, z}];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] make_table(input int mode);
        logic [15:0] t;
        logic [3:0]  v;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            case (mode)
                0:       t[i] = v[3] & v[2];
                1:       t[i] = v[0];
                2:       t[i] = ^v;
                default: t[i] = (^v) ^ (i == 5);
            endcase
        end
        return t;
    endfunction

    // Reference model: sweep progress as elapsed cycles since the accepting edge.
    always @(posedge clk) begin
        exp_done = 1'b0;
        if (!rst_n) begin
            if (elapsed >= 0) void'(exp_q.pop_back());
            elapsed = -1;
            exp_tt  = '0;
        end else if (elapsed < 0) begin
            if (start) begin
                elapsed = 0;
                exp_tt  = '0;
                exp_q.push_back(fn_table);
            end
        end else begin
            elapsed++;
            if (elapsed % HOLD == 0) exp_tt[elapsed/HOLD-1] = fn_table[elapsed/HOLD-1];
            if (elapsed == SWEEP) begin
                elapsed  = -1;
                exp_done = 1'b1;
            end
        end
    end

    // Per-cycle monitor plus scoreboard pop on each done pulse.
    always @(negedge clk) begin
        exp_index = (elapsed >= 0) ? 4'(elapsed / HOLD) : 4'd0;
        check("busy", busy, elapsed >= 0);
        check("done", done, exp_done);
        check("index", index, exp_index);
        check("stimulus_xywz", {x, y, w, z}, exp_index);
        check("truth_table_live", truth_table, exp_tt);
        if (done) begin
            check("scoreboard_has_entry_at_done", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                exp_result = exp_q.pop_front();
                check("sweep_result", truth_table, exp_result);
`ifdef TT_SWEEP_CHECK_EN
                exp_errs = $countones(exp_result ^ GOLDEN);
                check("err_count", err_count, exp_errs);
                check("mismatch", mismatch, exp_errs != 0);
`endif
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (elapsed >= 0 && n < SWEEP + 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One-cycle start pulse, optionally with random start noise during the sweep.
    task automatic run_sweep(input logic [15:0] tbl, input bit noise);
        int n = 0;
        wait_idle();
        fn_table = tbl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (elapsed >= 0 && n < SWEEP + 10) begin
            start = noise && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (elapsed < 0) start = 1'b0;
            n++;
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(make_table(0), 1'b0);   // x & y -> F000
        run_sweep(make_table(1), 1'b0);   // z     -> AAAA

        // start held high across the sweep and its done cycle: two back-to-back sweeps.
        wait_idle();
        fn_table = make_table(2);
        start = 1'b1;
        repeat (SWEEP + 2) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset in the middle of vector 7, then a clean sweep.
        fn_table = 16'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < SWEEP && elapsed != 7 * HOLD + 3; n++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_sweep(16'($urandom), 1'b0);

        run_sweep(make_table(3), 1'b0);   // XOR with vector 5 inverted -> 69B6
        run_sweep(make_table(2), 1'b1);   // correct XOR -> 6996

        for (int k = 0; k < 4; k++) run_sweep(16'($urandom), 1'b1);

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

- Sequential stimulus-and-capture stage that sits directly upstream of the 4-input combinational `circuit` block (`f = F(x,y,w,z)`).
- On a start request it drives all 16 input combinations into `circuit` in ascending order, holding each for a fixed number of clock cycles.
- It samples the returned `f` once per vector and assembles a 16-bit truth-table word for downstream comparison or logging.

## Interface
Parameters:
- `HOLD_CYCLES`, default 10: cycles each vector is driven; legal range 2..255.
- `EXPECTED`, default 16'h0000: golden truth table. Present only with `TT_SWEEP_CHECK_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  sweep request; sampled only in IDLE.
- `f`  in  1  response from `circuit`.
- `x`, `y`, `w`, `z`  out  1 each  stimulus to `circuit`.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `index`  out  4  vector currently driven.
- `truth_table`  out  16  captured responses; bit *i* = `f` for vector *i*.
- `mismatch`  out  1  sticky compare-fail flag. Present only with `TT_SWEEP_CHECK_EN`.
- `err_count`  out  5  count of mismatching samples, 0..16. Present only with `TT_SWEEP_CHECK_EN`.

## Operation
- States:
  - IDLE → DRIVE on `start`=1.
  - DRIVE → DRIVE on each vector advance.
  - DRIVE → IDLE after vector 15 is sampled.
- Vector mapping: `{x,y,w,z} = index`, with `x` as MSB. Order is 0000, 0001, …, 1111.
- Hold counter: width ceil(log2(HOLD_CYCLES)). It runs 0..HOLD_CYCLES-1 during DRIVE and resets to 0 on every vector advance.
- Sample point: at the edge where the hold counter equals HOLD_CYCLES-1, `truth_table[index] <= f`. If `index`=15 the sweep ends; otherwise `index` increments.
- Start accept: `start` in IDLE clears `truth_table` to 0 and sets `index`=0, counter=0, `busy`=1.
- `start` while `busy` is ignored and has no effect on the sweep in progress.
- In IDLE: `x,y,w,z` = 0000 and `index`=0. `truth_table` holds its last completed value until the next accepted start.
- Reset (`rst_n`=0 at an edge, including mid-sweep) aborts the sweep immediately, with no `done` pulse. All outputs take their reset values.

## Timing
- Reset values:
  - state = IDLE.
  - `x`=`y`=`w`=`z`=0, `index`=0.
  - `busy`=0, `done`=0.
  - `truth_table`=16'h0000.
  - `mismatch`=0, `err_count`=0.
- Accept: `start` sampled high at edge E0 means `busy`=1 and vector 0 is driven from E0 onward.
- Each vector is driven for exactly HOLD_CYCLES cycles. `f` is sampled after HOLD_CYCLES-1 full cycles of settling.
- Completion: at edge E0 + 16·HOLD_CYCLES:
  - `truth_table` bit 15 is written.
  - `busy`→0, `done`→1, and the stimulus returns to 0000.
  - `done` falls at the next edge.
- `start` high in the same cycle that `done` is high is accepted, because the state is already IDLE. A new sweep then begins with no idle gap.
- No combinational path from `f` or `start` to any output.

## Configuration
- Macro `TT_SWEEP_CHECK_EN`.
- Defined: the `EXPECTED` parameter plus the `mismatch` and `err_count` outputs are compiled in.
  - At each sample point, if `f != EXPECTED[index]`, `err_count` increments (saturating at 16) and `mismatch` sets.
  - Both clear on an accepted start and on reset.
  - `mismatch` remains set after `done`.
- Undefined: no compare logic, ports, or parameter.
  - The block only sweeps and captures.
  - Sweep timing is identical in both builds.

## Test plan
- HOLD_CYCLES=4, `f = x & y`, pulse `start` → `busy` high for 64 cycles, `done` pulse at E0+64, `truth_table`=16'hF000, final drive 0000.
- HOLD_CYCLES=10, `f = z` → `truth_table`=16'hAAAA. Check on every cycle that `{x,y,w,z}` equals `index` and each value lasts exactly 10 cycles.
- `f = x^y^w^z`, hold `start` high throughout the sweep → single sweep, `truth_table`=16'h6996. A second sweep starts in the `done` cycle.
- Assert `rst_n`=0 for one edge while `index`=7 → all outputs return to their reset values, with no `done` pulse. A following `start` yields a full, correct sweep.
- With `TT_SWEEP_CHECK_EN` defined, `EXPECTED`=16'h6996, and `f` = XOR with vector 5 inverted → `truth_table`=16'h69B6, `err_count`=1, `mismatch`=1. A rerun with a correct `f` gives `err_count`=0 and `mismatch`=0.
